ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the multi-cycle NPC core. It holds the architectural PC, issues one instruction-memory read per instruction, and hands the fetched word to decode over a valid/ready handshake. It then waits for the execute/write-back stage to commit that instruction and report the branch/jump decision (taken flag plus target) before computing the next PC. Only one instruction is in flight at a time.

## Interface
- `RESET_PC`, default `32'h8000_0000`: PC value loaded on reset.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: read request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_addr` output 32: read address; always equal to the current PC.
- `imem_rsp_valid` input 1: read data valid.
- `imem_rsp_data` input 32: instruction word.
- `inst_valid` output 1: fetched instruction available to decode.
- `inst_ready` input 1: decode accepts the instruction.
- `inst` output 32: instruction word.
- `inst_pc` output 32: PC of `inst`.
- `wb_valid` input 1: one-cycle pulse; the handed-off instruction has committed.
- `jump_taken` input 1: the PC-adder B-select decision (jump, or branch condition true); sampled with `wb_valid`.
- `jump_target` input 32: target address; sampled with `wb_valid`.
- `fetch_misalign` output 1: misaligned-target trap flag (see Configuration).
- `misalign_addr` output 32: offending target address.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, HOLD, WAIT_WB, TRAP.
  - IDLE: reset state. Moves unconditionally to REQ on the next edge.
  - REQ: `imem_req_valid`=1. On `imem_req_valid & imem_req_ready`, moves to WAIT_RSP.
  - WAIT_RSP: on `imem_rsp_valid`, latches `imem_rsp_data` into `inst` and moves to HOLD.
  - HOLD: `inst_valid`=1. On `inst_valid & inst_ready`, moves to WAIT_WB.
  - WAIT_WB: on `wb_valid`, loads the next PC and moves to REQ.
- Next PC:
  - `jump_taken`=1: `jump_target`.
  - `jump_taken`=0: `pc + 32'd4`. Addition is modulo 2^32, so `32'hFFFF_FFFC` wraps to 0.
- `inst_pc` is a registered copy of the PC, captured when the request fires.
- Inputs ignored outside their state:
  - `imem_rsp_valid` outside WAIT_RSP.
  - `wb_valid` outside WAIT_WB.
  - `imem_req_ready` outside REQ.
  - None of these change state, PC or outputs.
- Reset values: state=IDLE; pc=`RESET_PC`; `inst`=0; `inst_pc`=`RESET_PC`; `imem_req_valid`=0; `inst_valid`=0; `fetch_misalign`=0; `misalign_addr`=0.
- Reset mid-operation: `rst_n` low in any state immediately forces all reset values. Any in-flight request or instruction is abandoned. A late response after reset is ignored, because the FSM is not in WAIT_RSP.

## Timing
- `imem_req_valid`, `inst_valid` and `fetch_misalign` are decoded from registered state only; they have no combinational path from inputs.
- First request: `imem_req_valid` rises in the cycle after the first edge following `rst_n` deassertion.
- `imem_addr` is stable while `imem_req_valid`=1.
- `inst` and `inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
- Response may arrive no earlier than the cycle after request acceptance. A response in the same cycle as acceptance is ignored.
- Zero-wait-state loop is 4 cycles per instruction: REQ → WAIT_RSP → HOLD → WAIT_WB, with ready/rsp/wb each asserted at the first opportunity.
- The new PC appears on `imem_addr` in the cycle after `wb_valid` is sampled.

## Configuration
- `IFU_MISALIGN_TRAP_EN` defined:
  - In WAIT_WB, `wb_valid & jump_taken & (jump_target[1:0] != 0)` moves to TRAP instead of REQ.
  - `misalign_addr` latches `jump_target`; the PC is not updated.
  - TRAP asserts `fetch_misalign`=1 and issues no further requests. TRAP is exited only by reset.
- `IFU_MISALIGN_TRAP_EN` undefined:
  - TRAP is unreachable.
  - A taken target is loaded as `{jump_target[31:2], 2'b00}`.
  - `fetch_misalign` and `misalign_addr` are tied to 0.

## Test plan
- Reset, then `imem_req_ready`=1 and a response 1 cycle after acceptance with data `32'h0000_0013`. Required: `imem_addr`=`32'h8000_0000`; `inst_valid` rises 2 cycles after request acceptance with `inst`=`32'h0000_0013` and `inst_pc`=`32'h8000_0000`.
- Hold `inst_ready`=0 for 5 cycles. Required: `inst` and `inst_pc` stay constant and no new request is issued. `inst_ready`=1 then `wb_valid` with `jump_taken`=0 gives next `imem_addr`=`32'h8000_0004`.
- `wb_valid` with `jump_taken`=1 and `jump_target`=`32'h8000_0100`. Required: next `imem_addr`=`32'h8000_0100`.
- PC=`32'hFFFF_FFFC` with not-taken commit. Required: next `imem_addr`=`32'h0000_0000`.
- Spurious `wb_valid` in HOLD and spurious `imem_rsp_valid` in WAIT_WB. Required: no state or PC change. Assert `rst_n`=0 in WAIT_RSP. Required: all reset values immediately, and the first request is again to `RESET_PC`.
- Taken target `32'h8000_0102`. With `IFU_MISALIGN_TRAP_EN`: `fetch_misalign`=1, `misalign_addr`=`32'h8000_0102`, no further requests. Without it: next `imem_addr`=`32'h8000_0100`.

Source files
------------

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-issue instruction fetch unit holding the architectural PC
// Optional misaligned-target trap enabled by defining IFU_MISALIGN_TRAP_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        wb_valid,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        fetch_misalign,
  output logic [31:0] misalign_addr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    HOLD     = 3'd3,
    WAIT_WB  = 3'd4,
    TRAP     = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        trap_hit;

  assign imem_addr = pc;

  // Taken targets are word-aligned; in the trap build misaligned ones never reach the PC.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jump_taken) begin
      next_pc = {jump_target[31:2], 2'b00};
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic [31:0] misalign_addr_q;

  assign trap_hit       = jump_taken & (jump_target[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
  assign misalign_addr  = misalign_addr_q;
`else
  logic unused_target_lsbs;

  assign trap_hit           = 1'b0;
  assign unused_target_lsbs = ^jump_target[1:0];
  assign fetch_misalign     = 1'b0;
  assign misalign_addr      = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      inst           <= 32'd0;
      inst_pc        <= RESET_PC;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT_RSP;
            imem_req_valid <= 1'b0;
            inst_pc        <= pc;
          end
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            state      <= HOLD;
            inst       <= imem_rsp_data;
            inst_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            state      <= WAIT_WB;
            inst_valid <= 1'b0;
          end
        end
        WAIT_WB: begin
          if (wb_valid) begin
            if (trap_hit) begin
              state <= TRAP;
`ifdef IFU_MISALIGN_TRAP_EN
              misalign_q      <= 1'b1;
              misalign_addr_q <= jump_target;
`endif
            end else begin
              state          <= REQ;
              pc             <= next_pc;
              imem_req_valid <= 1'b1;
            end
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized self-checking bench for ifu_fetch
// Misaligned-target expectations follow IFU_MISALIGN_TRAP_EN.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        wb_valid;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        fetch_misalign;
  logic [31:0] misalign_addr;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_pc;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .wb_valid       (wb_valid),
    .jump_taken     (jump_taken),
    .jump_target    (jump_target),
    .fetch_misalign (fetch_misalign),
    .misalign_addr  (misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full fetch/commit round trip from a cycle where a request is expected.
  task automatic run_instr(input int req_dly, input int rsp_dly, input int rdy_dly, input int wb_dly,
                           input logic [31:0] data, input logic taken, input logic [31:0] tgt,
                           input logic spur_rsp);
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
      miscompares++;
      $display("FAIL req_issue: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_addr, m_pc);
    end
    for (int i = 0; i < req_dly; i++) begin
      imem_req_ready = 1'b0;
      step();
      vectors++;
      if (imem_req_valid !== 1'b1 || imem_addr !== m_pc) begin
        miscompares++;
        $display("FAIL req_stable: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_addr, m_pc);
      end
    end
    imem_req_ready = 1'b1;
    imem_rsp_valid = spur_rsp;
    imem_rsp_data  = ~data;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_accept: req_valid=%b inst_valid=%b, required 0 0", imem_req_valid, inst_valid);
    end
    repeat (rsp_dly) step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    vectors++;
    if (inst_valid !== 1'b1 || inst !== data || inst_pc !== m_pc) begin
      miscompares++;
      $display("FAIL inst_handoff: valid=%b inst=%h pc=%h, required 1 %h %h", inst_valid, inst, inst_pc, data, m_pc);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      wb_valid    = 1'($urandom % 2);
      jump_taken  = 1'b1;
      jump_target = $urandom;
      step();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== data || inst_pc !== m_pc || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b inst=%h pc=%h req=%b, required 1 %h %h 0",
                 inst_valid, inst, inst_pc, imem_req_valid, data, m_pc);
      end
    end
    wb_valid   = 1'b0;
    jump_taken = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL after_handoff: inst_valid=%b req=%b, required 0 0", inst_valid, imem_req_valid);
    end
    for (int i = 0; i < wb_dly; i++) begin
      imem_rsp_valid = 1'($urandom % 2);
      imem_rsp_data  = $urandom;
      step();
      vectors++;
      if (inst !== data || inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== m_pc) begin
        miscompares++;
        $display("FAIL wait_wb_stable: inst=%h valid=%b req=%b addr=%h, required %h 0 0 %h",
                 inst, inst_valid, imem_req_valid, imem_addr, data, m_pc);
      end
    end
    imem_rsp_valid = 1'b0;
    wb_valid    = 1'b1;
    jump_taken  = taken;
    jump_target = tgt;
    step();
    wb_valid   = 1'b0;
    jump_taken = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    if (taken && tgt[1:0] != 2'b00) begin
      vectors++;
      if (fetch_misalign !== 1'b1 || misalign_addr !== tgt || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL trap_enter: misalign=%b addr=%h req=%b, required 1 %h 0", fetch_misalign, misalign_addr, imem_req_valid, tgt);
      end
      imem_req_ready = 1'b1;
      repeat (4) step();
      imem_req_ready = 1'b0;
      vectors++;
      if (fetch_misalign !== 1'b1 || imem_req_valid !== 1'b0 || imem_addr !== m_pc) begin
        miscompares++;
        $display("FAIL trap_stay: misalign=%b req=%b pc=%h, required 1 0 %h", fetch_misalign, imem_req_valid, imem_addr, m_pc);
      end
      return;
    end
`endif
    m_pc = taken ? (tgt & ~32'd3) : m_pc + 32'd4;
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== m_pc || fetch_misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL next_pc: req=%b addr=%h misalign=%b, required 1 %h 0", imem_req_valid, imem_addr, fetch_misalign, m_pc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    inst_ready = 1'b0; wb_valid = 1'b0; jump_taken = 1'b0; jump_target = 32'd0;
    repeat (3) step();
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC || inst !== 32'd0 ||
        inst_pc !== RST_PC || fetch_misalign !== 1'b0 || misalign_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_values: req=%b iv=%b addr=%h inst=%h ipc=%h mis=%b maddr=%h",
               imem_req_valid, inst_valid, imem_addr, inst, inst_pc, fetch_misalign, misalign_addr);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h, required 1 %h", imem_req_valid, imem_addr, RST_PC);
    end
    m_pc = RST_PC;
  endtask

  task automatic test_basic();
    run_instr(0, 0, 5, 0, 32'h0000_0013, 1'b0, 32'd0, 1'b0);
    run_instr(0, 0, 0, 0, $urandom, 1'b1, 32'h8000_0100, 1'b1);
  endtask

  task automatic test_wrap();
    run_instr(1, 0, 0, 1, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_instr(0, 0, 0, 0, $urandom, 1'b0, 32'h1234_5678, 1'b0);
    run_instr(0, 1, 1, 0, $urandom, 1'b1, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        tk;
      logic [31:0] tg;
      tk = 1'($urandom % 2);
      tg = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
      tg[1:0] = 2'b00;
`endif
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom, tk, tg, 1'($urandom % 2));
    end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC || inst !== 32'd0 ||
        inst_pc !== RST_PC || fetch_misalign !== 1'b0 || misalign_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset: req=%b iv=%b addr=%h inst=%h ipc=%h mis=%b",
               imem_req_valid, inst_valid, imem_addr, inst, inst_pc, fetch_misalign);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC || inst_valid !== 1'b0 || inst !== 32'd0) begin
      miscompares++;
      $display("FAIL late_rsp: req=%b addr=%h iv=%b inst=%h, required 1 %h 0 0", imem_req_valid, imem_addr, inst_valid, inst, RST_PC);
    end
    imem_rsp_valid = 1'b0;
    m_pc = RST_PC;
    run_instr(0, 0, 0, 0, $urandom, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_misalign();
    run_instr(0, 0, 0, 0, $urandom, 1'b1, 32'h8000_0102, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_reset_mid();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
